// File: rtl/laser_frame_receiver.sv
// Oversampling serial receiver for one laser link: idle dark, start lit, 8 data bits LSB first, stop dark.
// Define LASER_RX_PARITY_EN to add an even-parity bit between data bit 7 and the stop bit.
module laser_frame_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       laser_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

`ifdef LASER_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic          sync_reg;
    logic          rx_s;
    logic          rx_prev;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic [7:0]    data_out_reg, data_out_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;
    logic          perr_reg, perr_next;
`ifdef LASER_RX_PARITY_EN
    logic          par_reg, par_next;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg     <= 1'b0;
            rx_s         <= 1'b0;
            rx_prev      <= 1'b0;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shreg_reg    <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            perr_reg     <= 1'b0;
`ifdef LASER_RX_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            sync_reg     <= laser_in;
            rx_s         <= sync_reg;
            rx_prev      <= rx_s;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shreg_reg    <= shreg_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
            perr_reg     <= perr_next;
`ifdef LASER_RX_PARITY_EN
            par_reg      <= par_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shreg_next    = shreg_reg;
        data_out_next = data_out_reg;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;
        perr_next     = 1'b0;
`ifdef LASER_RX_PARITY_EN
        par_next      = par_reg;
`endif
        if (!en) begin
            state_next   = IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Edge-triggered start: a line stuck lit must go dark before it can start again.
                    if (rx_s && !rx_prev) begin
                        state_next   = START;
                        cnt_next     = '0;
                        bit_idx_next = '0;
                    end
                end
                START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_next     = '0;
                        bit_idx_next = '0;
                        state_next   = rx_s ? DATA : IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        shreg_next   = {rx_s, shreg_reg[7:1]};
                        cnt_next     = '0;
                        bit_idx_next = bit_idx_reg + 1'b1;
                        if (bit_idx_reg == BIT_LAST) begin
`ifdef LASER_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef LASER_RX_PARITY_EN
                PARITY: begin
                    if (cnt_reg == CNT_LAST) begin
                        par_next   = rx_s;
                        cnt_next   = '0;
                        state_next = STOP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        if (rx_s) begin
                            ferr_next = 1'b1;
`ifdef LASER_RX_PARITY_EN
                        end else if (^{shreg_reg, par_reg}) begin
                            perr_next = 1'b1;
`endif
                        end else begin
                            data_out_next = shreg_reg;
                            valid_next    = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign data_out      = data_out_reg;
    assign data_valid    = valid_reg;
    assign framing_error = ferr_reg;
    assign parity_error  = perr_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Directed bench for laser_frame_receiver; expected pulses are queued when a frame is driven
// and matched (kind, byte, cycle) by a monitor on the falling clock edge.
module tb_laser_frame_receiver;

    localparam int CPB = 8;
`ifdef LASER_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // start mid-sample + data/parity/stop bits + output register + two synchronizer stages
    localparam int LAT = CPB / 2 + NBITS * CPB + 1 + 2;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       laser_in = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] model_data = 8'h00;
    exp_t exp_q[$];

    laser_frame_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock(clock),
        .reset(reset),
        .en(en),
        .laser_in(laser_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .framing_error(framing_error),
        .parity_error(parity_error),
        .busy(busy)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (!reset && (data_valid || framing_error || parity_error)) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed kind=%b data_out=%h at cycle %0d, required no pulse",
                       {parity_error, framing_error, data_valid}, data_out, cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({parity_error, framing_error, data_valid} === e.kind) else begin
                    errors++;
                    $error("FAIL pulse_kind: observed %b required %b",
                           {parity_error, framing_error, data_valid}, e.kind);
                end
                checks++;
                assert (data_out === e.data) else begin
                    errors++;
                    $error("FAIL data_out: observed %h required %h", data_out, e.data);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL pulse_cycle: observed %0d required %0d", cyc, e.cyc);
                end
            end
            $display("pulse kind=%b data_out=%h cycle=%0d", {parity_error, framing_error, data_valid}, data_out, cyc);
        end
        if (!reset && data_valid) begin
            checks++;
            assert (prev_valid === 1'b0) else begin
                errors++;
                $error("FAIL valid_width: observed data_valid high 2 cycles, required 1");
            end
        end
        prev_valid = data_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        laser_in = b;
        cycles(CPB);
    endtask

    task automatic push_exp(input logic [2:0] k, input logic [7:0] d, input int c);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
        $display("check %s observed=%h required=%h", tag, obs, req);
    endtask

    // Good frames carry correct even parity when the parity bit is compiled in.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        if (stop_b) begin
            push_exp(K_FERR, model_data, cyc + LAT);
        end else begin
            push_exp(K_VALID, d, cyc + LAT);
            model_data = d;
        end
        drive_bit(1'b1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef LASER_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

`ifdef LASER_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] d, input logic p);
        if (^{d, p}) begin
            push_exp(K_PERR, model_data, cyc + LAT);
        end else begin
            push_exp(K_VALID, d, cyc + LAT);
            model_data = d;
        end
        drive_bit(1'b1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(1'b0);
    endtask
`endif

    initial begin
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_flags", {4'h0, data_valid, framing_error, parity_error, busy}, 8'h00);
        cycles(3);
        reset = 1'b0;
        cycles(5);

        send_frame(8'h08, 1'b0);
        cycles(2);
        check("busy_after_08", {7'h0, busy}, 8'h00);
        check("data_out_08", data_out, 8'h08);

        send_frame(8'h17, 1'b0);
        send_frame(8'hA5, 1'b0);
        check("data_out_a5", data_out, 8'hA5);

        // Short lit glitch: START entered, then aborted at mid-bit.
        laser_in = 1'b1;
        cycles(2);
        laser_in = 1'b0;
        cycles(2);
        check("glitch_busy_start", {7'h0, busy}, 8'h01);
        cycles(20);
        check("glitch_busy_idle", {7'h0, busy}, 8'h00);

        // Stuck lit: one all-ones attempt ending in a framing error, then no retrigger.
        push_exp(K_FERR, model_data, cyc + LAT);
        laser_in = 1'b1;
        cycles(400);
        check("stuck_busy", {7'h0, busy}, 8'h00);
        laser_in = 1'b0;
        cycles(10);

        send_frame(8'h3C, 1'b1);
        cycles(2);
        check("data_out_after_ferr", data_out, 8'hA5);

        // Reset during data bit 4 of 0xFF.
        laser_in = 1'b1;
        cycles(CPB * 5 + CPB / 2);
        reset = 1'b1;
        #1;
        check("midreset_data_out", data_out, 8'h00);
        check("midreset_flags", {4'h0, data_valid, framing_error, parity_error, busy}, 8'h00);
        model_data = 8'h00;
        laser_in = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(10);
        send_frame(8'h55, 1'b0);
        cycles(2);
        check("data_out_55", data_out, 8'h55);

`ifdef LASER_RX_PARITY_EN
        send_par_frame(8'h07, 1'b0);
        cycles(2);
        check("data_out_bad_par", data_out, 8'h55);
        send_par_frame(8'h07, 1'b1);
        cycles(2);
        check("data_out_07", data_out, 8'h07);
`endif

        // Enable dropped mid-frame: partial byte discarded silently.
        laser_in = 1'b1;
        cycles(CPB * 2);
        en = 1'b0;
        laser_in = 1'b0;
        cycles(5);
        check("en_low_busy", {7'h0, busy}, 8'h00);
        en = 1'b1;
        cycles(120);
        check("en_restore_busy", {7'h0, busy}, 8'h00);
        check("en_data_out", data_out, model_data);

        send_frame(8'hC3, 1'b0);
        cycles(5);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL missing_pulses: observed %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
